// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with edge-detected pending bits
// and an IDLE/REQ/SERVICE handshake with the CPU.
module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h00007f20,
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [NSRC-1:0] mask, mask_n, pend, pend_n, src_q, rise, clr, pm;
  logic [2:0] id, id_n, low;
  logic armed, sel, wr, ack, eoi, busy;
  logic [1:0] off;
  logic [31:0] cur;
  logic unused;
  assign sel = Addr >= BASE_ADDR && Addr <= BASE_ADDR + 32'd15;
  assign off = Addr[3:2];
  assign wr = sel && WE;
  assign ack = state == REQ && int_ack;
  assign eoi = state == SERVICE && wr && off == 2'd3;
  // armed suppresses edge detection on the first sample after reset, so a
  // line already high at release must fall and rise before it is pended
  assign rise = armed ? irq_src & ~src_q : '0;
  assign clr = (wr && off == 2'd1 ? Din[NSRC-1:0] : '0) | (ack ? NSRC'(1) << id : '0);
  assign pend_n = (pend & ~clr) | rise;
  assign mask_n = wr && off == 2'd0 ? Din[NSRC-1:0] : mask;
  assign pm = pend & mask;
  always_comb begin
    low = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (pm[i]) low = 3'(i);
  end
  // REQ looks at next-cycle PEND/MASK so a software clear drops the request at once
  always_comb begin
    state_n = state;
    id_n = id;
    if (state == IDLE && pm != '0) begin
      state_n = REQ;
      id_n = low;
    end else if (ack) state_n = SERVICE;
    else if (state == REQ && !(pend_n[id] && mask_n[id])) state_n = IDLE;
    else if (eoi) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      pend <= '0;
      src_q <= '0;
      id <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      pend <= pend_n;
      src_q <= irq_src;
      id <= id_n;
      armed <= 1'b1;
    end
  assign busy = state == SERVICE;
  assign int_req = state == REQ;
  assign int_id = int_req ? id : 3'd0;
  assign cur = {28'b0, busy, busy ? id : 3'd0};
  assign Dout = !sel ? '0 : off == 2'd0 ? 32'(mask) : off == 2'd1 ? 32'(pend) : off == 2'd2 ? cur : '0;
  assign unused = ^Din;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl; expectations are queued as
// stimulus is applied and consumed in order as outputs are observed.
module tb_irq_ctrl;
  logic clk = 1'b0, reset = 1'b1, WE = 1'b0, int_ack = 1'b0, int_req;
  logic [5:0] irq_src = '0;
  logic [31:0] Addr = '0, Din = '0, Dout;
  logic [2:0] int_id;
  int vectors = 0, miscompares = 0;
  typedef struct {string tag; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  localparam logic [31:0] MASK = 32'h7f20, PEND = 32'h7f24, CUR = 32'h7f28, EOI = 32'h7f2c;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .int_req(int_req), .int_id(int_id), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", obs, 32'hffff_ffff);
      return;
    end
    e = sb.pop_front();
    check(e.tag, obs, e.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    WE = 1'b0;
    #1;
    d = Dout;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din = d;
    WE = 1'b1;
    tick();
    WE = 1'b0;
    Din = '0;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic obs_reg(input logic [31:0] a);
    logic [31:0] d;
    rd(a, d);
    pop(d);
  endtask

  task automatic obs_req();
    pop({31'b0, int_req});
  endtask

  task automatic obs_id();
    pop({29'b0, int_id});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push("rst_req", 0); push("rst_id", 0); push("rst_cur", 0);
    obs_req(); obs_id(); obs_reg(CUR);
    reset = 1'b0;
    tick(); tick();
    // basic request / ack / EOI on source 1
    wr(MASK, 32'h3);
    push("mask_rd", 32'h3); obs_reg(MASK);
    irq_src[1] = 1'b1;
    push("t1_pend", 32'h2); push("t1_req0", 0); push("t1_req", 1); push("t1_id", 1);
    tick(); obs_reg(PEND); obs_req();
    tick(); obs_req(); obs_id();
    push("t1_pend_ack", 0); push("t1_cur_svc", 32'h9); push("t1_req_svc", 0);
    ack_pulse(); obs_reg(PEND); obs_reg(CUR); obs_req();
    push("t1_cur_eoi", 0); push("t1_req_eoi", 0);
    wr(EOI, 0); obs_reg(CUR); tick(); obs_req();
    irq_src[1] = 1'b0; tick();
    // simultaneous sources 0 and 3: lowest first
    wr(MASK, 32'h3f); irq_src = 6'h09;
    push("t2_id0", 0); push("t2_req0", 1); push("t2_cur0", 32'h8); push("t2_id3", 3); push("t2_req3", 1);
    tick(); tick(); obs_id(); obs_req();
    ack_pulse(); obs_reg(CUR);
    wr(EOI, 0); tick(); obs_id(); obs_req();
    ack_pulse(); wr(EOI, 0); irq_src = '0; tick();
    // masked pending, then unmask
    wr(MASK, 0); irq_src[2] = 1'b1;
    push("t3_pend", 32'h4); push("t3_req_masked", 0); push("t3_req", 1); push("t3_id", 2);
    tick(); tick(); obs_reg(PEND); obs_req();
    wr(MASK, 32'h4); tick(); obs_req(); obs_id();
    ack_pulse(); wr(EOI, 0); irq_src = '0; tick();
    // W1C withdraws a request; same-cycle edge wins over W1C
    wr(MASK, 32'h2); irq_src[1] = 1'b1;
    push("t4_id", 1); push("t4_req_w1c", 0); push("t4_pend_w1c", 0);
    tick(); tick(); obs_id();
    wr(PEND, 32'h2); obs_req(); obs_reg(PEND);
    irq_src[1] = 1'b0; tick();
    irq_src[1] = 1'b1; tick();
    irq_src[1] = 1'b0; tick();
    push("t4_pend_race", 32'h2); push("t4_req_race", 1);
    irq_src[1] = 1'b1; wr(PEND, 32'h2); obs_reg(PEND); obs_req();
    ack_pulse(); wr(EOI, 0); irq_src = '0; tick();
    // stray ack / EOI in IDLE, out-of-window reads
    push("t5_req_ack", 0); push("t5_cur_ack", 0); push("t5_cur_eoi", 0); push("t5_pend", 0);
    push("t5_above", 0); push("t5_below", 0);
    ack_pulse(); obs_req(); obs_reg(CUR);
    wr(EOI, 0); obs_reg(CUR); obs_reg(PEND); obs_reg(32'h7f30);
    tick(); obs_reg(32'h7f10);
    // reset during SERVICE with source 0 held high
    wr(MASK, 32'h1); irq_src[0] = 1'b1;
    push("t6_cur_svc", 32'h8); push("t6_req_rst", 0); push("t6_cur_rst", 0);
    push("t6_pend_rel", 0); push("t6_req_rel", 0); push("t6_req_tog", 1); push("t6_id_tog", 0);
    tick(); tick(); ack_pulse(); obs_reg(CUR);
    reset = 1'b1; #1; obs_req(); obs_reg(CUR);
    tick(); tick(); reset = 1'b0;
    wr(MASK, 32'h1); tick(); tick(); obs_reg(PEND); obs_req();
    irq_src[0] = 1'b0; tick();
    irq_src[0] = 1'b1; tick(); tick(); obs_req(); obs_id();
    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00007f20, the byte base of the 16-byte register window.
REQ-002 SHALL have parameter NSRC, default 6, the number of interrupt sources (1..8).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port irq_src  input  NSRC  level interrupt lines; bit0 = timer0 IRQ0, bit1 = timer1 IRQ1, others external.
REQ-006 SHALL have port Addr  input  32  CPU data address.
REQ-007 SHALL have port WE  input  1  CPU store enable.
REQ-008 SHALL have port Din  input  32  CPU store data.
REQ-009 SHALL have port Dout  output  32  register read data, combinational from Addr.
REQ-010 SHALL have port int_req  output  1  interrupt request to CPU.
REQ-011 SHALL have port int_id  output  3  index of the requested source.
REQ-012 SHALL have port int_ack  input  1  one-cycle CPU pulse: exception entry taken.

Function
REQ-013 SHALL decode sel = (Addr >= BASE_ADDR) && (Addr <= BASE_ADDR+15); register offset = Addr[3:2]; writes only when sel && WE.
REQ-014 SHALL implement MASK at offset 0: RW, bits [NSRC-1:0], 1 = enabled; other bits read 0.
REQ-015 SHALL implement PEND at offset 1: read returns pending bits; write-1-to-clear per bit.
REQ-016 SHALL implement CUR at offset 2: RO, {28'b0, busy, id[2:0]}, busy = 1 in SERVICE.
REQ-017 SHALL implement EOI at offset 3: any write ends service; reads return 0.
REQ-018 SHALL drive Dout = 0 when sel = 0.
REQ-019 SHALL keep a registered copy of irq_src and set PEND[i] on each sampled rising edge (prev 0, now 1) of irq_src[i].
REQ-020 SHALL give a rising-edge set priority over a same-cycle PEND clear (W1C or ack) on the same bit.
REQ-021 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-022 IDLE: when (PEND & MASK) != 0, SHALL latch id = lowest set index of (PEND & MASK) and go to REQ next cycle.
REQ-023 REQ: SHALL drive int_req = 1 and int_id = latched id; id SHALL NOT change while in REQ, even if a lower index becomes pending.
REQ-024 REQ: on int_ack SHALL clear PEND[id] and go to SERVICE next cycle; int_req = 0 from that cycle.
REQ-025 REQ: if PEND[id] or MASK[id] becomes 0 (software write) without int_ack, SHALL return to IDLE; int_ack takes precedence in the same cycle.
REQ-026 SERVICE: SHALL hold int_req = 0 and CUR.busy = 1; on an EOI write SHALL go to IDLE.
REQ-027 SHALL ignore int_ack outside REQ and EOI writes outside SERVICE.
REQ-028 Latency: edge sampled at cycle N sets PEND at N+1; FSM enters REQ at N+2, int_req high from N+2 if masked-in and IDLE.
REQ-029 SHALL clamp int_id and CUR.id to 0 when not in REQ/SERVICE respectively.

Reset
REQ-030 On reset SHALL asynchronously clear MASK, PEND, irq_src copy, latched id; FSM = IDLE.
REQ-031 During and after reset SHALL drive int_req = 0, int_id = 0, CUR = 0.
REQ-032 Reset in REQ or SERVICE SHALL abandon the interrupt with no pending bit retained; a source already high at release SHALL NOT set PEND until it falls and rises again.

Verification
REQ-033 MASK=0x03, irq_src[1] 0->1 -> PEND=0x02, int_req=1, int_id=1 two cycles later; int_ack -> PEND=0, CUR=0x9; EOI write -> CUR=0, int_req stays 0.
REQ-034 MASK=0x3F, irq_src[0] and [3] rise same cycle -> int_id=0; after ack+EOI, second request int_id=3.
REQ-035 MASK=0x00, irq_src[2] rises -> PEND=0x04, int_req=0; write MASK=0x04 -> int_req=1, int_id=2 within 2 cycles.
REQ-036 In REQ with id=1, write PEND=0x02 (W1C) -> FSM IDLE, int_req=0 next cycle; same-cycle edge on bit1 -> PEND[1] stays 1.
REQ-037 Stray int_ack in IDLE and EOI write in IDLE -> no state change; read of Addr=0x7f30 -> Dout=0.
REQ-038 Assert reset in SERVICE with irq_src[0] held high -> int_req=0, CUR=0, PEND=0 after release, no request until irq_src[0] toggles.
